// File: rtl/adc_frame_packer_if.sv
// -----------------------------------------------------------------------------
// adc_frame_packer_if
//   Byte-stream handshake between the frame packer and its consumer
//   (FT245 sync TX path).
//   o_data  : byte presented by the packer
//   o_valid : o_data valid
//   i_ready : consumer takes the byte when o_valid && i_ready at posedge
//   master  : packer side, slave : consumer side
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface adc_frame_packer_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input  i_ready);
    modport slave  (input  o_data, input  o_valid, output i_ready);
endinterface

// File: rtl/adc_frame_packer.sv
// -----------------------------------------------------------------------------
// adc_frame_packer
//   Packs 4-channel 14-bit ADC sample sets into 10-byte frames:
//     HDR_BYTE, seq, then per channel c: {c[1:0], s[13:8]}, s[7:0]
//   One set can wait in a pending register while another is serialized from
//   the active register, so frames run back-to-back at one byte per cycle.
//   Ports:
//     i_clk, i_rst        : clock, asynchronous active-high reset
//     i_enable            : capture enable (never aborts a frame in flight)
//     i_sample_valid      : one-cycle strobe for i_sample0..3
//     i_sample0..3        : 14-bit channel samples
//     tx (master)         : o_data / o_valid / i_ready byte stream
//     o_overrun_cnt       : saturating count of dropped sets
//     o_busy              : frame in progress or set pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_frame_packer #(
    parameter logic [7:0] HDR_BYTE = 8'hA5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_sample_valid,
    input  logic [13:0]            i_sample0,
    input  logic [13:0]            i_sample1,
    input  logic [13:0]            i_sample2,
    input  logic [13:0]            i_sample3,
    output logic [7:0]             o_overrun_cnt,
    output logic                   o_busy,
    adc_frame_packer_if.master     tx
);

    typedef enum logic [1:0] {IDLE, HDR, SEQ, DATA} state_t;

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [7:0]       seq_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             pend_vld_q, pend_vld_d;
    logic [7:0]       ovr_q, ovr_d;
    logic [3:0][13:0] pend_q;
    logic [3:0][13:0] act_q;

    logic accept, last_acc, xfer, cap_req, capture, drop;

    // Data byte idx (0..7) of the active set: even = channel tag + high bits.
    function automatic logic [7:0] data_byte(input logic [3:0][13:0] s,
                                             input logic [2:0] idx);
        logic [13:0] w;
        w = s[idx[1+:2]];
        return idx[0] ? w[7:0] : {idx[1+:2], w[13:8]};
    endfunction

    always_comb begin
        accept   = valid_q && tx.i_ready;
        last_acc = accept && (state_q == DATA) && (idx_q == 3'd7);
        xfer     = pend_vld_q && ((state_q == IDLE) || last_acc);
        cap_req  = i_sample_valid && i_enable;
        // A full pending slot can still take a new set if it empties this cycle.
        capture  = cap_req && (!pend_vld_q || xfer);
        drop     = cap_req && !capture;

        pend_vld_d = pend_vld_q;
        if (capture)   pend_vld_d = 1'b1;
        else if (xfer) pend_vld_d = 1'b0;

        ovr_d = ovr_q;
        if (drop && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_vld_q <= 1'b0;
            ovr_q      <= 8'h00;
        end else begin
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    // Sample storage carries no reset; the flags above qualify it.
    always_ff @(posedge i_clk) begin
        if (capture) pend_q <= {i_sample3, i_sample2, i_sample1, i_sample0};
        if (xfer)    act_q  <= pend_q;
    end

    // Serializer FSM. o_data/o_valid are registered and only move on accept,
    // which keeps them stable across stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            seq_q   <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_q <= HDR;
                        data_q  <= HDR_BYTE;
                        valid_q <= 1'b1;
                    end
                end
                HDR: begin
                    if (accept) begin
                        state_q <= SEQ;
                        data_q  <= seq_q;
                    end
                end
                SEQ: begin
                    if (accept) begin
                        state_q <= DATA;
                        idx_q   <= 3'd0;
                        data_q  <= data_byte(act_q, 3'd0);
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (idx_q == 3'd7) begin
                            seq_q <= seq_q + 8'd1;
                            idx_q <= 3'd0;
                            if (pend_vld_q) begin
                                // Pending moves to active this same edge.
                                state_q <= HDR;
                                data_q  <= HDR_BYTE;
                            end else begin
                                state_q <= IDLE;
                                data_q  <= 8'h00;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            idx_q  <= idx_q + 3'd1;
                            data_q <= data_byte(act_q, idx_q + 3'd1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx.o_data     = data_q;
    assign tx.o_valid    = valid_q;
    assign o_overrun_cnt = ovr_q;
    assign o_busy        = (state_q != IDLE) || pend_vld_q;

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5, frame header byte value.
REQ-002 SHALL have port i_clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_enable  input  1  capture enable; low: new sample sets ignored.
REQ-005 SHALL have port i_sample_valid  input  1  one-cycle strobe; i_sample0..3 valid this cycle.
REQ-006 SHALL have ports i_sample0, i_sample1, i_sample2, i_sample3  input  14 each  ADC channel samples (ADC1 A/B, ADC2 A/B).
REQ-007 SHALL have port o_data  output  8  byte stream toward FT245 sync TX path.
REQ-008 SHALL have port o_valid  output  1  o_data valid.
REQ-009 SHALL have port i_ready  input  1  consumer accepts byte when o_valid && i_ready at posedge.
REQ-010 SHALL have port o_overrun_cnt  output  8  dropped sample sets, saturating.
REQ-011 SHALL have port o_busy  output  1  high while a frame is being emitted or a set is pending.

Function
REQ-012 SHALL emit per accepted set a 10-byte frame: HDR_BYTE, seq[7:0], then per channel c=0..3 byte {c[1:0], sample_c[13:8]} then sample_c[7:0].
REQ-013 SHALL hold a pending register (4x14 bits + pending flag) and an active register feeding the serializer.
REQ-014 SHALL capture into pending when i_sample_valid && i_enable && (pending empty or pending transfers to active in that same cycle).
REQ-015 SHALL, when i_sample_valid && i_enable with pending full and no transfer that cycle, drop the set and increment o_overrun_cnt, saturating at 8'hFF.
REQ-016 SHALL transfer pending to active when state is IDLE, or when the last byte (index 9) is accepted, and pending is full; pending flag clears unless REQ-014 refills it same cycle.
REQ-017 SHALL use states IDLE, HDR, SEQ, DATA; IDLE->HDR on transfer; HDR->SEQ and SEQ->DATA on accept; DATA advances a 3-bit byte index on accept; index 7 accepted -> HDR if pending full, else IDLE.
REQ-018 SHALL assert o_valid in HDR, SEQ, DATA only; o_valid low in IDLE.
REQ-019 SHALL keep o_data and o_valid stable while o_valid && !i_ready; no byte skipped or repeated.
REQ-020 SHALL sustain one byte per cycle with i_ready held high, back-to-back frames with no idle cycle when pending full.
REQ-021 SHALL increment 8-bit seq by 1 (wrap 8'hFF->8'h00) when the last byte of a frame is accepted.
REQ-022 Latency: i_sample_valid at cycle N with module IDLE and pending empty -> pending full at N+1, HDR byte on o_data with o_valid=1 at N+2.
REQ-023 Deasserting i_enable SHALL NOT abort an in-progress frame nor discard pending; it only blocks new captures and does not count overruns.
REQ-024 o_busy SHALL equal (state != IDLE) || pending flag.

Reset
REQ-025 SHALL on i_rst asynchronously force: state IDLE, o_valid 0, o_data 8'h00, pending flag 0, byte index 0, seq 8'h00, o_overrun_cnt 8'h00, o_busy 0.
REQ-026 Reset mid-frame SHALL discard active and pending data; first frame after reset starts with seq 8'h00.
REQ-027 Sample data registers need no reset value.

Verification
REQ-028 Single set {14'h1234,14'h0ABC,14'h3FFF,14'h0000}, i_ready=1 -> bytes A5,00,12,34,4A,BC,BF,FF,C0,00, o_valid from N+2 for 10 cycles.
REQ-029 i_ready toggled 1/0 every cycle during frame -> identical byte sequence, each byte held while i_ready=0.
REQ-030 Three sets 2 cycles apart with i_ready=0 -> first active, second pending, third dropped; o_overrun_cnt=1; after release two frames with seq 00,01.
REQ-031 300 dropped sets while stalled -> o_overrun_cnt saturates at FF.
REQ-032 257 frames streamed -> seq of frame 257 is 8'h00; frames contiguous when pending always refilled.
REQ-033 i_rst pulsed during DATA index 3 -> o_valid 0 immediately, o_busy 0; next set yields seq 00 frame.
